// File: rtl/xil_bram_fifo_fwft.sv
// First-word-fall-through FIFO controller for an external SDP block RAM.
// A DEL+1 entry prefetch buffer hides the RAM read latency from the consumer.
module xil_bram_fifo_fwft #(
  parameter int ADR = 10,
  parameter int DAT = 18,
  parameter int DEL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [DAT-1:0] pdat,
  output logic           full,
  input  logic           pop,
  output logic           vld,
  output logic [DAT-1:0] odat,
  output logic [ADR:0]   lvl,
  output logic           ovf,
  output logic           udf,
  output logic           wen,
  output logic [ADR-1:0] wad,
  output logic [DAT-1:0] wda,
  output logic           ren,
  output logic [ADR-1:0] rad,
  input  logic [DAT-1:0] rda
);

  localparam int OB = DEL + 1;
  localparam int OW = (OB > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam int LW = ADR + 1;
  localparam logic [ADR:0] DEPTH = {1'b1, {ADR{1'b0}}};

  logic [ADR-1:0] wptr;
  logic [ADR-1:0] rptr;
  logic [ADR:0]   rcnt;
  logic [DEL-1:0] vpipe;
  logic [CW-1:0]  ocnt;
  logic [CW-1:0]  ifl;
  logic [CW-1:0]  used;
  logic [OW-1:0]  head;
  logic [OW-1:0]  tail;
  logic [DAT-1:0] obuf [OB];
  logic           wr;
  logic           rd;
  logic           land;

  function automatic logic [OW-1:0] nxt(
    input logic [OW-1:0] p
  );
    return (p == OW'(OB - 1)) ? '0 : p + 1'b1;
  endfunction

  // write strobe is held off while reset is asserted
  assign full = (lvl == DEPTH);
  assign wr   = push & ~full & rst;
  assign wen  = wr;
  assign wad  = wptr;
  assign wda  = pdat;

  assign vld  = (ocnt != '0);
  assign odat = obuf[head];
  assign rd   = pop & vld;
  assign land = vpipe[DEL-1];
  assign rad  = rptr;

  always_comb begin
    ifl = '0;
    for (int i = 0; i < DEL; i++)
      ifl = ifl + CW'(vpipe[i]);
  end

  // slots already claimed after this cycle's pop
  assign used = ocnt + ifl - CW'(rd);
  assign ren  = (rcnt != '0) && (used < CW'(OB));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      rcnt  <= '0;
      vpipe <= '0;
      lvl   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (ren)
        rptr <= rptr + 1'b1;
      rcnt <= rcnt + LW'(wr) - LW'(ren);
      vpipe[0] <= ren;
      for (int i = 1; i < DEL; i++)
        vpipe[i] <= vpipe[i-1];
      unique case ({wr, rd})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
      ovf <= push & full;
      udf <= pop & ~vld;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      ocnt <= '0;
      for (int i = 0; i < OB; i++)
        obuf[i] <= '0;
    end else begin
      if (land) begin
        obuf[tail] <= rda;
        tail       <= nxt(tail);
      end
      if (rd)
        head <= nxt(head);
      ocnt <= ocnt + CW'(land) - CW'(rd);
    end
  end

endmodule

// File: tb/tb_xil_bram_fifo_fwft.sv
// Bench for xil_bram_fifo_fwft at DEL=1 and DEL=2, each with a behavioural
// SDP RAM, checked against queue models of the FIFO contents.
module tb_xil_bram_fifo_fwft;

  localparam int ADR = 10;
  localparam int DAT = 18;
  localparam int DEPTH = 1 << ADR;

  typedef struct {
    logic [DAT-1:0] d;
    int             t;
  } ent_t;

  typedef struct {
    logic           ps;
    logic [DAT-1:0] pd;
    logic           pp;
    logic           wen;
    logic [ADR-1:0] wad;
    logic           ren;
    logic [ADR-1:0] rad;
    int             lvl;
    logic           v1;
    logic           v2;
    logic [DAT-1:0] od;
    logic           udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [DAT-1:0] pdat = '0;

  logic [1:0] full, vld, ovf, udf, wen, ren;
  logic [1:0][DAT-1:0] odat, wda, rda;
  logic [1:0][ADR:0] lvl;
  logic [1:0][ADR-1:0] wad, rad;

  logic [DAT-1:0] mem [2][DEPTH];
  logic [DAT-1:0] r1, r2a, r2b;

  ent_t q [2][$];
  int wcnt [2];
  int rcnt [2];
  int pcnt [2];
  logic e_ovf [2];
  logic e_udf [2];
  int cyc;
  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  xil_bram_fifo_fwft #(.ADR(ADR), .DAT(DAT), .DEL(1)) u1 (
    .clk(clk), .rst(rst), .push(push), .pdat(pdat),
    .full(full[0]), .pop(pop), .vld(vld[0]), .odat(odat[0]),
    .lvl(lvl[0]), .ovf(ovf[0]), .udf(udf[0]),
    .wen(wen[0]), .wad(wad[0]), .wda(wda[0]),
    .ren(ren[0]), .rad(rad[0]), .rda(rda[0])
  );

  xil_bram_fifo_fwft #(.ADR(ADR), .DAT(DAT), .DEL(2)) u2 (
    .clk(clk), .rst(rst), .push(push), .pdat(pdat),
    .full(full[1]), .pop(pop), .vld(vld[1]), .odat(odat[1]),
    .lvl(lvl[1]), .ovf(ovf[1]), .udf(udf[1]),
    .wen(wen[1]), .wad(wad[1]), .wda(wda[1]),
    .ren(ren[1]), .rad(rad[1]), .rda(rda[1])
  );

  // SDP RAMs with registered read, one and two stages deep
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (wen[k]) mem[k][wad[k]] <= wda[k];
    if (ren[0]) r1 <= mem[0][rad[0]];
    if (ren[1]) r2a <= mem[1][rad[1]];
    r2b <= r2a;
  end

  assign rda[0] = r1;
  assign rda[1] = r2b;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [DEL=%0d] cyc %0d: got %0h want %0h",
               nm, k + 1, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      wcnt[k] = 0;
      rcnt[k] = 0;
      pcnt[k] = 0;
      e_ovf[k] = 1'b0;
      e_udf[k] = 1'b0;
    end
  endtask

  task automatic model();
    for (int k = 0; k < 2; k++) begin
      int n = q[k].size();
      int inb;
      logic acc_w;
      logic acc_r;
      ent_t e;
      chk("lvl", k, 32'(lvl[k]), 32'(n));
      chk("full", k, 32'(full[k]), 32'(n == DEPTH));
      chk("ovf", k, 32'(ovf[k]), 32'(e_ovf[k]));
      chk("udf", k, 32'(udf[k]), 32'(e_udf[k]));
      if (n == 0)
        chk("vld_empty", k, 32'(vld[k]), 32'(0));
      else if (q[k][0].t <= cyc - (k + 3))
        chk("vld_live", k, 32'(vld[k]), 32'(1));
      if (vld[k] && n > 0)
        chk("odat", k, 32'(odat[k]), 32'(q[k][0].d));
      acc_w = push && (n < DEPTH);
      chk("wen", k, 32'(wen[k]), 32'(acc_w));
      if (acc_w) begin
        chk("wad", k, 32'(wad[k]), 32'(wcnt[k] % DEPTH));
        chk("wda", k, 32'(wda[k]), 32'(pdat));
      end
      acc_r = pop && vld[k];
      chk("ren_no_data", k, 32'(ren[k] && (rcnt[k] >= wcnt[k])), 32'(0));
      if (ren[k]) begin
        chk("rad", k, 32'(rad[k]), 32'(rcnt[k] % DEPTH));
        rcnt[k]++;
      end
      inb = rcnt[k] - pcnt[k] - int'(acc_r);
      chk("prefetch_bound", k, 32'(inb > k + 2), 32'(0));
      e_ovf[k] = push && (n == DEPTH);
      e_udf[k] = pop && !vld[k];
      if (acc_r) begin
        if (n > 0) e = q[k].pop_front();
        pcnt[k]++;
      end
      if (acc_w) begin
        q[k].push_back('{pdat, cyc});
        wcnt[k]++;
      end
    end
    cyc++;
  endtask

  task automatic step(input logic ps, input logic [DAT-1:0] pd,
                      input logic pp);
    @(posedge clk);
    #1;
    push = ps;
    pdat = pd;
    pop = pp;
    @(negedge clk);
    model();
  endtask

  task automatic drain();
    int i = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && i < 4000) begin
      step(1'b0, '0, 1'b1);
      i++;
    end
    step(1'b0, '0, 1'b0);
    for (int k = 0; k < 2; k++)
      chk("drain_lvl", k, 32'(lvl[k]), 32'(0));
  endtask

  task automatic rst_chk();
    for (int k = 0; k < 2; k++) begin
      chk("rst_vld", k, 32'(vld[k]), 32'(0));
      chk("rst_full", k, 32'(full[k]), 32'(0));
      chk("rst_lvl", k, 32'(lvl[k]), 32'(0));
      chk("rst_wen", k, 32'(wen[k]), 32'(0));
      chk("rst_ren", k, 32'(ren[k]), 32'(0));
      chk("rst_odat", k, 32'(odat[k]), 32'(0));
      chk("rst_ovf", k, 32'(ovf[k]), 32'(0));
      chk("rst_udf", k, 32'(udf[k]), 32'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv [9];
    logic ev;
    logic seen [2];
    int stall;
    logic pp;

    tv[0] = '{1'b1, 18'h0A5, 1'b0, 1'b1, 10'd0, 1'b0, 10'd0, 0,
              1'b0, 1'b0, 18'h0, 1'b0};
    tv[1] = '{1'b1, 18'h1B6, 1'b0, 1'b1, 10'd1, 1'b1, 10'd0, 1,
              1'b0, 1'b0, 18'h0, 1'b0};
    tv[2] = '{1'b0, 18'h0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd1, 2,
              1'b0, 1'b0, 18'h0, 1'b0};
    tv[3] = '{1'b0, 18'h0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 2,
              1'b1, 1'b0, 18'h0A5, 1'b0};
    tv[4] = '{1'b0, 18'h0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 2,
              1'b1, 1'b1, 18'h0A5, 1'b0};
    tv[5] = '{1'b0, 18'h0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1,
              1'b1, 1'b1, 18'h1B6, 1'b0};
    tv[6] = '{1'b0, 18'h0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 0,
              1'b0, 1'b0, 18'h0, 1'b0};
    tv[7] = '{1'b0, 18'h0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 0,
              1'b0, 1'b0, 18'h0, 1'b1};
    tv[8] = '{1'b0, 18'h0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 0,
              1'b0, 1'b0, 18'h0, 1'b0};

    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_chk();
    rst = 1'b1;

    // first word latency, pop, underflow
    for (int i = 0; i < 9; i++) begin
      step(tv[i].ps, tv[i].pd, tv[i].pp);
      for (int k = 0; k < 2; k++) begin
        ev = (k == 0) ? tv[i].v1 : tv[i].v2;
        chk("t_wen", k, 32'(wen[k]), 32'(tv[i].wen));
        if (tv[i].wen)
          chk("t_wad", k, 32'(wad[k]), 32'(tv[i].wad));
        chk("t_ren", k, 32'(ren[k]), 32'(tv[i].ren));
        if (tv[i].ren)
          chk("t_rad", k, 32'(rad[k]), 32'(tv[i].rad));
        chk("t_lvl", k, 32'(lvl[k]), 32'(tv[i].lvl));
        chk("t_vld", k, 32'(vld[k]), 32'(ev));
        if (ev)
          chk("t_odat", k, 32'(odat[k]), 32'(tv[i].od));
        chk("t_udf", k, 32'(udf[k]), 32'(tv[i].udf));
      end
    end

    // fill to full, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, DAT'(i), 1'b0);
    step(1'b1, 18'h3FFFF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("fill_full", k, 32'(full[k]), 32'(1));
      chk("fill_lvl", k, 32'(lvl[k]), 32'(DEPTH));
      chk("ovf_wen", k, 32'(wen[k]), 32'(0));
    end
    step(1'b0, '0, 1'b0);
    for (int k = 0; k < 2; k++)
      chk("ovf_pulse", k, 32'(ovf[k]), 32'(1));
    drain();

    // streaming push+pop, no bubbles, address wrap
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      step(1'b1, DAT'(i), 1'b1);
      for (int k = 0; k < 2; k++) begin
        if (seen[k])
          chk("no_bubble", k, 32'(vld[k]), 32'(1));
        seen[k] = seen[k] | vld[k];
      end
    end
    drain();

    // asynchronous reset with five words held
    for (int i = 0; i < 5; i++)
      step(1'b1, DAT'(100 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    push = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    rst_chk();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    rst = 1'b1;
    step(1'b1, 18'h3, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_vld", k, 32'(vld[k]), 32'(1));
      chk("post_rst_odat", k, 32'(odat[k]), 32'(3));
    end
    drain();

    // random traffic with pop stalls of 1-5 cycles
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (stall > 0) begin
        stall--;
        pp = 1'b0;
      end else begin
        pp = 1'b1;
        if ($urandom_range(0, 3) == 0)
          stall = int'($urandom_range(1, 5));
      end
      step($urandom_range(0, 9) < 6, DAT'($urandom), pp);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xil_bram_fifo_fwft.md
# xil_bram_fifo_fwft

Single-clock first-word-fall-through FIFO controller that drives an external simple-dual-port block RAM (the depth-composed SDP BRAM wrapper, write and read ports tied to the same clock). It generates the RAM write and read strobes and addresses, absorbs the RAM read latency in a small output buffer, and presents a valid/pop handshake with no read-latency bubbles. It sits directly in front of, and consumes the read data from, the SDP RAM in every buffering path of the datapath.

## Interface
- ADR, 10, RAM address width; FIFO depth DEPTH = 2^ADR words
- DAT, 18, data width
- DEL, 1, RAM read latency in cycles (1 or 2), must match the RAM's DEL
- clk  in  1  clock, shared by controller and RAM (both RAM clocks)
- rst  in  1  asynchronous, active-low reset
- push  in  1  write request
- pdat  in  DAT  write data
- full  out  1  FIFO holds DEPTH words
- pop  in  1  consume head word (valid only when vld=1)
- vld  out  1  odat holds the head word
- odat  out  DAT  head word
- lvl  out  ADR+1  total words held (RAM + in flight + output buffer)
- ovf  out  1  one-cycle pulse: push while full
- udf  out  1  one-cycle pulse: pop while vld=0
- wen  out  1  RAM write enable
- wad  out  ADR  RAM write address
- wda  out  DAT  RAM write data
- ren  out  1  RAM read enable
- rad  out  ADR  RAM read address
- rda  in  DAT  RAM read data, valid DEL cycles after ren

## Operation
- Accepted write: wr = push & ~full. wen = wr, wad = wptr, wda = pdat (combinational); wptr increments, wraps at DEPTH.
- rcnt: words written to RAM but not yet read out; +1 on wr, -1 on ren, registered.
- Output buffer: register FIFO of DEL+1 entries; ocnt = entries held; ifl = reads in flight (0..DEL), tracked by a DEL-stage valid shift register alongside ren.
- Prefetch: ren = (rcnt != 0) & (ocnt + ifl - (pop & vld) < DEL+1). rad = rptr; rptr increments on ren, wraps at DEPTH.
- rda is written into the output buffer on the cycle its in-flight valid bit emerges; occupancy is bounded by the prefetch rule, so the buffer never overflows.
- vld = (ocnt != 0); odat = head entry; pop & vld removes head.
- lvl: +1 on wr, -1 on pop & vld, both together leave it unchanged. full = (lvl == DEPTH).
- Pop while vld=0: ignored, udf pulses next cycle. Push while full: ignored (no wen), ovf pulses next cycle.
- A word written in cycle t is readable from RAM at t+1 at the earliest, since rcnt is registered; same-address read/write in one cycle never occurs.
- Reset (any time, async): wptr, rptr, rcnt, ocnt, in-flight bits, lvl cleared; vld=0, full=0, ovf=udf=0, wen=ren=0; odat=0. Data in flight is discarded.

## Timing
- Empty FIFO, push at cycle t: wen at t; lvl=1 from t+1; ren at t+1; rda at t+1+DEL; vld=1 from t+2+DEL (DEL=1: 3 cycles; DEL=2: 4 cycles).
- Steady state push and pop every cycle: one word out per cycle, no bubbles after the initial latency; lvl constant.
- Pop effective in its own cycle: next head visible in the following cycle when the buffer holds ≥2 entries.
- full asserts the cycle after the DEPTH-th accepted write; deasserts the cycle after a pop & vld.
- ovf and udf are registered, one cycle wide.

## Test plan
- Reset: drive rst low mid-stream with lvl=5 -> vld=0, full=0, lvl=0, wen=ren=0 immediately; after release, new push 0x3 emerges first.
- DEL=1, push 0x00A5 at cycle 0 into an empty FIFO -> wen=1, wad=0 at 0; ren=1, rad=0 at 1; vld=1, odat=0x00A5 at 3.
- Fill with pop=0: 1024 pushes -> full=1, lvl=1024; 1025th push -> wen=0, ovf pulse, lvl stays 1024; drain yields 0..1023 in order.
- Continuous push+pop of 0..2047 (DEL=1 and DEL=2) -> odat in order, no bubble after first vld, wad/rad wrap 1023->0, full never asserts.
- pop with vld=0 -> udf pulse one cycle later, lvl unchanged; random push/pop with pop stalls of 1-5 cycles -> scoreboard match, lvl always equals pushes minus pops.
